// File: rtl/minterm_scan.sv
// rtl/minterm_scan.sv - sweeps a 4-input function block through all 16 minterms and captures its truth table
// Optional MATCH output against EXPECT is built when MINTERM_SCAN_MATCH_EN is defined.
module minterm_scan #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'h38F0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        Y,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] TT,
`ifdef MINTERM_SCAN_MATCH_EN
  output logic        MATCH,
`endif
  output logic [4:0]  ONES
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  ones_q, ones_d;
  logic        done_q, done_d;
  logic [15:0] tt_sample;

  // Table with the bit for the current index replaced by the live Y.
  assign tt_sample = (tt_q & ~(16'd1 << idx_q)) | (16'(Y) << idx_q);

`ifdef MINTERM_SCAN_MATCH_EN
  logic match_q, match_d;
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
`ifdef MINTERM_SCAN_MATCH_EN
    match_d = match_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          idx_d   = 4'd0;
          cnt_d   = SETTLE_C;
          tt_d    = 16'd0;
          ones_d  = 5'd0;
`ifdef MINTERM_SCAN_MATCH_EN
          match_d = 1'b0;
`endif
        end
      end
      default: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tt_d   = tt_sample;
          ones_d = ones_q + {4'd0, Y};
          if (idx_q != 4'hF) begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_C;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef MINTERM_SCAN_MATCH_EN
            match_d = (tt_sample == EXPECT);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 16'd0;
      ones_q  <= 5'd0;
      done_q  <= 1'b0;
`ifdef MINTERM_SCAN_MATCH_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
`ifdef MINTERM_SCAN_MATCH_EN
      match_q <= match_d;
`endif
    end
  end

  assign {A, B, C, D} = idx_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;
  assign TT   = tt_q;
  assign ONES = ones_q;
`ifdef MINTERM_SCAN_MATCH_EN
  assign MATCH = match_q;
`endif

endmodule

// File: tb/tb_minterm_scan.sv
// tb/tb_minterm_scan.sv - self-checking bench for minterm_scan with SETTLE=0, 1 and 3 instances
module tb_minterm_scan;

  logic        CLK;
  logic        RST;
  logic        start_r [3];
  logic        y_w     [3];
  logic        a_w     [3];
  logic        b_w     [3];
  logic        c_w     [3];
  logic        d_w     [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [15:0] tt_w    [3];
  logic [4:0]  ones_w  [3];
  logic [3:0]  idx_w   [3];
`ifdef MINTERM_SCAN_MATCH_EN
  logic        match_w [3];
`endif

  int          mode_r [3];
  logic [15:0] tab_r  [3];
  int          checks;
  int          passes;

  function automatic int settle_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  // Function block model: 0 tied low, 1 tied high, 2 minterm sum, 3 arbitrary table.
  function automatic logic y_model(input int mode, input logic [15:0] tab, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (i inside {4, 5, 6, 7, 11, 12, 13});
      default: return tab[i];
    endcase
  endfunction

  function automatic logic [15:0] model_tt(input int mode, input logic [15:0] tab);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = y_model(mode, tab, i);
    return t;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      minterm_scan #(.SETTLE(settle_of(g)), .EXPECT(16'h38F0)) u_dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (start_r[g]),
        .Y     (y_w[g]),
        .A     (a_w[g]),
        .B     (b_w[g]),
        .C     (c_w[g]),
        .D     (d_w[g]),
        .BUSY  (busy_w[g]),
        .DONE  (done_w[g]),
        .TT    (tt_w[g]),
`ifdef MINTERM_SCAN_MATCH_EN
        .MATCH (match_w[g]),
`endif
        .ONES  (ones_w[g])
      );
      assign idx_w[g] = {a_w[g], b_w[g], c_w[g], d_w[g]};
      assign y_w[g]   = y_model(mode_r[g], tab_r[g], int'(idx_w[g]));
    end
  endgenerate

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, ":abcd"}, 32'(idx_w[d]), 0);
    chk({tag, ":busy"}, 32'(busy_w[d]), 0);
    chk({tag, ":done"}, 32'(done_w[d]), 0);
    chk({tag, ":tt"},   32'(tt_w[d]), 0);
    chk({tag, ":ones"}, 32'(ones_w[d]), 0);
`ifdef MINTERM_SCAN_MATCH_EN
    chk({tag, ":match"}, 32'(match_w[d]), 0);
`endif
  endtask

  // One sweep from START to DONE with optional ignored START pulses and a restart in the DONE cycle.
  task automatic run_sweep(input int d, input int mid_idx, input bit final_start,
                           input bit restart, input string tag);
    int lat;
    int m;
    bit mid_done;
    logic [15:0] exp_tt;
    lat = 16 * (settle_of(d) + 1);
    exp_tt = model_tt(mode_r[d], tab_r[d]);
    @(negedge CLK);
    start_r[d] = 1'b1;
    for (int r = 0; r < (restart ? 2 : 1); r++) begin
      @(posedge CLK);
      @(negedge CLK);
      start_r[d] = 1'b0;
      chk({tag, ":busy_on"}, 32'(busy_w[d]), 1);
      chk({tag, ":tt_clr"},  32'(tt_w[d]), 0);
      chk({tag, ":ones_clr"}, 32'(ones_w[d]), 0);
      chk({tag, ":done_off"}, 32'(done_w[d]), 0);
`ifdef MINTERM_SCAN_MATCH_EN
      chk({tag, ":match_clr"}, 32'(match_w[d]), 0);
`endif
      m = 0;
      mid_done = 1'b0;
      while (!done_w[d] && m < lat + 4) begin
        if (r == 0 && mid_idx >= 0 && !mid_done && int'(idx_w[d]) == mid_idx) begin
          start_r[d] = 1'b1;
          mid_done = 1'b1;
        end
        if (r == 0 && final_start && m == lat - 1) start_r[d] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_r[d] = 1'b0;
        m++;
      end
      chk({tag, ":latency"}, 32'(m), 32'(lat));
      chk({tag, ":busy_off"}, 32'(busy_w[d]), 0);
      chk({tag, ":tt"}, 32'(tt_w[d]), 32'(exp_tt));
      chk({tag, ":ones"}, 32'(ones_w[d]), 32'($countones(exp_tt)));
      chk({tag, ":abcd_hold"}, 32'(idx_w[d]), 32'hF);
`ifdef MINTERM_SCAN_MATCH_EN
      chk({tag, ":match"}, 32'(match_w[d]), 32'(exp_tt == 16'h38F0));
`endif
      if (restart && r == 0) begin
        start_r[d] = 1'b1;
      end else begin
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ":done_pulse"}, 32'(done_w[d]), 0);
        chk({tag, ":tt_hold"}, 32'(tt_w[d]), 32'(exp_tt));
      end
    end
  endtask

  typedef struct {
    int          d;
    int          mode;
    logic [15:0] exp_tt;
    int          exp_ones;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   dn;
    bit   found;
    checks = 0;
    passes = 0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      mode_r[i]  = 0;
      tab_r[i]   = 16'h0;
    end
    RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    vecs[0] = '{1, 2, 16'h38F0, 7};
    vecs[1] = '{0, 1, 16'hFFFF, 16};
    vecs[2] = '{0, 0, 16'h0000, 0};
    vecs[3] = '{2, 2, 16'h38F0, 7};
    vecs[4] = '{1, 1, 16'hFFFF, 16};
    for (int v = 0; v < 5; v++) begin
      mode_r[vecs[v].d] = vecs[v].mode;
      chk($sformatf("vec%0d:tt_const", v), 32'(model_tt(vecs[v].mode, 16'h0)), 32'(vecs[v].exp_tt));
      run_sweep(vecs[v].d, -1, 1'b0, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d:tt_tab", v), 32'(tt_w[vecs[v].d]), 32'(vecs[v].exp_tt));
      chk($sformatf("vec%0d:ones_tab", v), 32'(ones_w[vecs[v].d]), 32'(vecs[v].exp_ones));
    end

    for (int n = 0; n < 6; n++) begin
      dn = int'($urandom_range(0, 2));
      mode_r[dn] = 3;
      tab_r[dn]  = 16'($urandom);
      run_sweep(dn, -1, 1'b0, 1'b0, $sformatf("rand%0d", n));
    end

    // Ignored STARTs mid-sweep and on the final sample edge, then a restart in the DONE cycle.
    mode_r[1] = 2;
    run_sweep(1, 7, 1'b1, 1'b1, "restart");

    // Asynchronous reset while IDX=5 on the SETTLE=3 instance.
    mode_r[2] = 2;
    @(negedge CLK);
    start_r[2] = 1'b1;
    @(negedge CLK);
    start_r[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (idx_w[2] == 4'd5) found = 1'b1;
      else @(negedge CLK);
    end
    chk("abort:reach_idx5", 32'(found), 1);
    #2 RST = 1'b1;
    #1;
    chk_zero(2, "abort");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      if (done_w[2] || busy_w[2]) found = 1'b1;
    end
    chk("abort:no_done_no_busy", 32'(found), 0);
    run_sweep(2, -1, 1'b0, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/minterm_scan.md
MINTERM_SCAN -- requirements
Module: minterm_scan

Interface
REQ-001 Parameter SETTLE, default 1: extra hold cycles per input index before sampling Y; legal range 0..15.
REQ-002 Parameter EXPECT, default 16'h38F0: expected truth table, used only when MINTERM_SCAN_MATCH_EN is defined.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  sweep request, sampled on CLK.
REQ-006 Y  input  1  result returned by the downstream 4-input function block.
REQ-007 A  output  1  function input, MSB of index.
REQ-008 B, C  output  1 each  function inputs, middle index bits.
REQ-009 D  output  1  function input, LSB of index.
REQ-010 BUSY  output  1  high while a sweep is in progress.
REQ-011 DONE  output  1  one-cycle pulse at sweep completion.
REQ-012 TT  output  16  captured truth table; bit i = Y sampled with {A,B,C,D}=i.
REQ-013 ONES  output  5  count of ones in TT, range 0..16.

Function
REQ-014 The design SHALL have two states, IDLE and RUN, plus a 4-bit index register IDX driving {A,B,C,D} and a 4-bit hold counter CNT.
REQ-015 In IDLE with START=1 at edge k: IDX<=0, CNT<=SETTLE, TT<=0, ONES<=0, BUSY<=1, state<=RUN.
REQ-016 In RUN with CNT!=0: CNT<=CNT-1; IDX, TT and ONES hold.
REQ-017 In RUN with CNT==0 (sample edge): TT[IDX]<=Y, ONES<=ONES+Y.
REQ-018 At a sample edge with IDX!=15: IDX<=IDX+1, CNT<=SETTLE.
REQ-019 Each index SHALL be driven for exactly SETTLE+1 cycles; the sample for index i occurs at edge k+(i+1)*(SETTLE+1).
REQ-020 At the sample edge with IDX==15: state<=IDLE, BUSY<=0, DONE<=1; {A,B,C,D} hold 4'b1111.
REQ-021 DONE SHALL clear on the following edge; DONE is never high for more than one cycle.
REQ-022 TT and ONES SHALL hold their final values in IDLE until the next accepted START.
REQ-023 START while in RUN, including on the final sample edge, SHALL be ignored with no effect on timing or results.
REQ-024 START high in the cycle DONE is high (state IDLE) SHALL begin a new sweep per REQ-015.
REQ-025 ONES SHALL be computed by 5-bit addition; 16 ones yields 5'd16 with no wrap.

Reset
REQ-026 RST=1 SHALL immediately force state IDLE and A,B,C,D, BUSY, DONE, TT, ONES, IDX and CNT to 0, independent of CLK.
REQ-027 Reset during RUN SHALL abort the sweep with no DONE pulse; operation resumes only on a new START after RST deasserts.

Configuration
REQ-028 With MINTERM_SCAN_MATCH_EN defined, output MATCH (1 bit) SHALL exist: reset 0; cleared on accepted START; set to (final TT==EXPECT) on the edge DONE rises; held until the next START.
REQ-029 Without MINTERM_SCAN_MATCH_EN, the MATCH port and its comparison logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 SETTLE=1, Y from a behavioural model of sum-of-minterms (4,5,6,7,11,12,13), START pulse at edge k -> DONE high for one cycle after edge k+32, TT=16'h38F0, ONES=7, BUSY low from edge k+32.
REQ-031 SETTLE=0, Y tied 1 -> DONE after edge k+16, TT=16'hFFFF, ONES=16; Y tied 0 -> TT=16'h0000, ONES=0.
REQ-032 SETTLE=3, reset asserted while IDX=5 -> all outputs 0 immediately, no DONE pulse; new START afterwards completes normally at k'+64.
REQ-033 START re-pulsed at IDX=7 and again on the final sample edge -> DONE timing and TT unchanged from REQ-030; START in the DONE cycle -> new sweep, TT/ONES cleared on that edge.
REQ-034 With MINTERM_SCAN_MATCH_EN, REQ-030 stimulus -> MATCH=1 when DONE rises; Y tied 0 -> MATCH=0; MATCH returns to 0 on next START.
